// File: rtl/tmds_encoder_multi.sv
// NUM_CH-channel DVI TMDS encoder: 2-stage pipeline with one running-disparity counter per channel.
// Define HDMI_ISLAND_EN to add i_mode/i_aux for TERC4 data-island and video guard-band periods.
module tmds_encoder_multi #(
   parameter int NUM_CH = 3,
   parameter int DISP_W = 5
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [8*NUM_CH-1:0]        i_data,
   input  logic [2*NUM_CH-1:0]        i_ctrl,
   input  logic                       i_de,
`ifdef HDMI_ISLAND_EN
   input  logic [1:0]                 i_mode,
   input  logic [4*NUM_CH-1:0]        i_aux,
`endif
   output logic [10*NUM_CH-1:0]       o_tmds,
   output logic [DISP_W*NUM_CH-1:0]   o_disp
);

   typedef enum logic [1:0] {
      P_CTRL   = 2'b00,
      P_VIDEO  = 2'b01,
      P_ISLAND = 2'b10,
      P_GUARD  = 2'b11
   } period_t;

   localparam logic [9:0]              TOK_00    = 10'b1101010100;
   localparam logic signed [DISP_W-1:0] DISP_ZERO = '0;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   function automatic logic [9:0] ctrl_token(input logic [1:0] c);
      logic [9:0] t;
      case (c)
         2'b00:   t = 10'b1101010100;
         2'b01:   t = 10'b0010101011;
         2'b10:   t = 10'b0101010100;
         default: t = 10'b1010101011;
      endcase
      return t;
   endfunction

`ifdef HDMI_ISLAND_EN
   function automatic logic [9:0] terc4(input logic [3:0] n);
      logic [9:0] t;
      case (n)
         4'd0:    t = 10'b1010011100;
         4'd1:    t = 10'b1001100011;
         4'd2:    t = 10'b1011100100;
         4'd3:    t = 10'b1011100010;
         4'd4:    t = 10'b0101110001;
         4'd5:    t = 10'b0100011110;
         4'd6:    t = 10'b0110001110;
         4'd7:    t = 10'b0100111100;
         4'd8:    t = 10'b1011001100;
         4'd9:    t = 10'b0100111001;
         4'd10:   t = 10'b0110011100;
         4'd11:   t = 10'b1011000110;
         4'd12:   t = 10'b1010001110;
         4'd13:   t = 10'b1001110001;
         4'd14:   t = 10'b0101100011;
         default: t = 10'b1011000011;
      endcase
      return t;
   endfunction
`endif

   period_t in_period;
   period_t s1_period;

`ifdef HDMI_ISLAND_EN
   assign in_period = period_t'(i_mode);
`else
   assign in_period = i_de ? P_VIDEO : P_CTRL;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) s1_period <= P_CTRL;
      else       s1_period <= in_period;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      localparam bit GUARD_HI = (k % 3) == 1;

      logic [7:0]               d;
      logic [8:0]               qm_d;
      logic [8:0]               s1_qm;
      logic [1:0]               s1_ctrl;
      logic [9:0]               sym_d;
      logic [9:0]               sym_q;
      logic signed [DISP_W-1:0] cnt_d;
      logic signed [DISP_W-1:0] cnt_q;
`ifdef HDMI_ISLAND_EN
      logic [3:0]               s1_aux;
`endif

      assign d = i_data[8*k +: 8];

      // Stage 1: transition-minimised word q_m
      always_comb begin
         logic [3:0] n1;
         logic       use_xnor;
         n1       = popcount8(d);
         use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
         qm_d     = '0;
         qm_d[0]  = d[0];
         for (int unsigned i = 1; i < 8; i++)
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d[i]) : (qm_d[i-1] ^ d[i]);
         qm_d[8]  = ~use_xnor;
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            s1_qm   <= '0;
            s1_ctrl <= '0;
`ifdef HDMI_ISLAND_EN
            s1_aux  <= '0;
`endif
         end else begin
            s1_qm   <= qm_d;
            s1_ctrl <= i_ctrl[2*k +: 2];
`ifdef HDMI_ISLAND_EN
            s1_aux  <= i_aux[4*k +: 4];
`endif
         end
      end

      // Stage 2: DC balance; bal = n1q - n0q of q_m[7:0]
      always_comb begin
         int         bal;
         int         delta;
         logic [7:0] q;
         logic       q8;
         q     = s1_qm[7:0];
         q8    = s1_qm[8];
         bal   = 2 * int'(popcount8(q)) - 8;
         delta = 0;
         sym_d = ctrl_token(s1_ctrl);
         cnt_d = '0;
         case (s1_period)
            P_VIDEO: begin
               if ((cnt_q == DISP_ZERO) || (bal == 0)) begin
                  sym_d = {~q8, q8, q8 ? q : ~q};
                  delta = q8 ? bal : -bal;
               end else if (((cnt_q > DISP_ZERO) && (bal > 0)) ||
                            ((cnt_q < DISP_ZERO) && (bal < 0))) begin
                  sym_d = {1'b1, q8, ~q};
                  delta = (q8 ? 2 : 0) - bal;
               end else begin
                  sym_d = {1'b0, q8, q};
                  delta = bal - (q8 ? 0 : 2);
               end
               cnt_d = cnt_q + DISP_W'(delta);
            end
`ifdef HDMI_ISLAND_EN
            P_ISLAND: sym_d = terc4(s1_aux);
            P_GUARD:  sym_d = GUARD_HI ? 10'b0100110011 : 10'b1011001100;
`endif
            default: ;
         endcase
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            sym_q <= TOK_00;
            cnt_q <= '0;
         end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
         end
      end

      assign o_tmds[10*k +: 10]        = sym_q;
      assign o_disp[DISP_W*k +: DISP_W] = cnt_q;
   end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Scoreboard bench for tmds_encoder_multi: directed pixels plus random traffic scored against a
// behavioural TMDS/TERC4 model; expectations are queued per output clock edge and popped by a monitor.
`timescale 1ns/1ps
module tb_tmds_encoder_multi;
   localparam int NUM_CH = 3;
   localparam int DISP_W = 5;

   logic                       i_clk = 1'b0;
   logic                       i_rst;
   logic [8*NUM_CH-1:0]        i_data;
   logic [2*NUM_CH-1:0]        i_ctrl;
   logic                       i_de;
`ifdef HDMI_ISLAND_EN
   logic [1:0]                 i_mode;
   logic [4*NUM_CH-1:0]        i_aux;
`endif
   logic [10*NUM_CH-1:0]       o_tmds;
   logic [DISP_W*NUM_CH-1:0]   o_disp;

   tmds_encoder_multi #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_data(i_data),
      .i_ctrl(i_ctrl),
      .i_de  (i_de),
`ifdef HDMI_ISLAND_EN
      .i_mode(i_mode),
      .i_aux (i_aux),
`endif
      .o_tmds(o_tmds),
      .o_disp(o_disp)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int                        idx;
      logic [10*NUM_CH-1:0]      tmds;
      logic [DISP_W*NUM_CH-1:0]  disp;
   } exp_t;

   typedef struct {
      int         idx;
      int         ch;
      logic [9:0] sym;
      int         disp;
   } spot_t;

   exp_t  sb[$];
   spot_t spots[$];
   int    total = 0;
   int    bad   = 0;
   int    stim_k = 0;
   int    mon_k  = 0;
   int    m_cnt [NUM_CH];

   logic                p_rst = 1'b1;
   logic [1:0]          p_mode = 2'b00;
   logic [8*NUM_CH-1:0] p_data = '0;
   logic [2*NUM_CH-1:0] p_ctrl = '0;
   logic [4*NUM_CH-1:0] p_aux  = '0;

   logic [9:0] ctrl_tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   logic [9:0] terc4_tab [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s edge=%0d got=%h exp=%h", name, mon_k, got, exp);
      end
   endtask

   // Behavioural encoder: q_m bits as prefix parities, disparity as a plain integer.
   function automatic logic [9:0] model_sym(input int ch, input logic [1:0] mode, input logic [7:0] d,
                                            input logic [1:0] c, input logic [3:0] a);
      int         n1, n1q, n0q, b, cnt;
      bit         xn;
      logic [8:0] qm;
      logic [7:0] msk;
      logic [9:0] s;
      cnt = m_cnt[ch];
      case (mode)
         2'b01: begin
            n1 = $countones(d);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            for (int i = 0; i < 8; i++) begin
               msk   = 8'hFF >> (7 - i);
               qm[i] = 1'(($countones(d & msk) + (xn ? i : 0)) % 2);
            end
            qm[8] = xn ? 1'b0 : 1'b1;
            b   = int'(qm[8]);
            n1q = $countones(qm[7:0]);
            n0q = 8 - n1q;
            if (cnt == 0 || n1q == n0q) begin
               s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
               cnt += (b == 1) ? (n1q - n0q) : (n0q - n1q);
            end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
               s = {1'b1, qm[8], ~qm[7:0]};
               cnt += 2 * b + (n0q - n1q);
            end else begin
               s = {1'b0, qm[8], qm[7:0]};
               cnt += -2 * (1 - b) + (n1q - n0q);
            end
         end
         2'b10: begin s = terc4_tab[a]; cnt = 0; end
         2'b11: begin s = ((ch % 3) == 1) ? 10'b0100110011 : 10'b1011001100; cnt = 0; end
         default: begin s = ctrl_tok[c]; cnt = 0; end
      endcase
      m_cnt[ch] = cnt;
      return s;
   endfunction

   // Applies one input vector (sampled at edge stim_k) and queues the output expected at that edge.
   task automatic drive_core(input logic rst, input logic [1:0] mode, input logic [8*NUM_CH-1:0] data,
                             input logic [2*NUM_CH-1:0] ctrl, input logic [4*NUM_CH-1:0] aux);
      exp_t e;
      i_rst  = rst;
      i_data = data;
      i_ctrl = ctrl;
`ifdef HDMI_ISLAND_EN
      i_mode = mode;
      i_aux  = aux;
      i_de   = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
`else
      i_de   = (mode == 2'b01);
`endif
      stim_k++;
      e.idx = stim_k;
      if (rst || p_rst) begin
         for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
         e.tmds = {NUM_CH{ctrl_tok[0]}};
         e.disp = '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            e.tmds[10*c +: 10]        = model_sym(c, p_mode, p_data[8*c +: 8], p_ctrl[2*c +: 2], p_aux[4*c +: 4]);
            e.disp[DISP_W*c +: DISP_W] = DISP_W'(m_cnt[c]);
         end
      end
      sb.push_back(e);
      p_rst  = rst;
      p_mode = mode;
      p_data = data;
      p_ctrl = ctrl;
      p_aux  = aux;
   endtask

   task automatic cyc(input logic rst, input logic [1:0] mode, input logic [8*NUM_CH-1:0] data,
                      input logic [2*NUM_CH-1:0] ctrl, input logic [4*NUM_CH-1:0] aux);
      @(negedge i_clk);
      drive_core(rst, mode, data, ctrl, aux);
   endtask

   task automatic spot(input int at, input int ch, input logic [9:0] sym, input int disp);
      spot_t s;
      s = '{at, ch, sym, disp};
      spots.push_back(s);
   endtask

   task automatic spot_all_tok0(input int at);
      for (int c = 0; c < NUM_CH; c++) spot(at, c, 10'b1101010100, 0);
   endtask

   function automatic logic [7:0] rnd_byte();
      case ($urandom_range(0, 5))
         0:       return 8'h00;
         1:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   // Monitor: samples 1 ns after each rising edge and retires that edge's expectations.
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         mon_k++;
         while (sb.size() > 0 && sb[0].idx <= mon_k) begin
            exp_t e;
            e = sb.pop_front();
            if (e.idx == mon_k) begin
               chk("tmds", 64'(o_tmds), 64'(e.tmds));
               chk("disp", 64'(o_disp), 64'(e.disp));
            end else begin
               chk("sb_stale", 64'(e.idx), 64'(mon_k));
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            int dv;
            dv = int'($signed(o_disp[DISP_W*c +: DISP_W]));
            total++;
            if (dv > 10 || dv < -10) begin
               bad++;
               $display("FAIL disp_range ch=%0d edge=%0d got=%0d allowed=-10..10", c, mon_k, dv);
            end
         end
         while (spots.size() > 0 && spots[0].idx <= mon_k) begin
            spot_t s;
            s = spots.pop_front();
            if (s.idx == mon_k) begin
               chk($sformatf("spot_sym_ch%0d", s.ch), 64'(o_tmds[10*s.ch +: 10]), 64'(s.sym));
               chk($sformatf("spot_disp_ch%0d", s.ch),
                   64'(int'($signed(o_disp[DISP_W*s.ch +: DISP_W]))), 64'(s.disp));
            end else begin
               chk("spot_stale", 64'(s.idx), 64'(mon_k));
            end
         end
      end
   end

   initial begin
      logic [8*NUM_CH-1:0] rd;
      logic [2*NUM_CH-1:0] rc;
      logic [4*NUM_CH-1:0] ra;
      logic [1:0]          rm;
      logic                rr;

      // reset held 3 cycles, then released into control period
      drive_core(1'b1, 2'b00, '0, '0, '0);
      spot_all_tok0(stim_k);
      repeat (2) begin
         cyc(1'b1, 2'b00, '0, '0, '0);
         spot_all_tok0(stim_k);
      end
      repeat (2) begin
         cyc(1'b0, 2'b00, '0, '0, '0);
         spot_all_tok0(stim_k);
      end

      // control tokens per channel, 2-cycle latency
      cyc(1'b0, 2'b00, '0, 6'b11_00_01, '0);
      spot(stim_k, 0, 10'b1101010100, 0);
      spot(stim_k + 1, 0, 10'b0010101011, 0);
      spot(stim_k + 1, 1, 10'b1101010100, 0);
      spot(stim_k + 1, 2, 10'b1010101011, 0);
      cyc(1'b0, 2'b00, '0, '0, '0);

      // 0x00 pixels from zero disparity
      cyc(1'b1, 2'b00, '0, '0, '0);
      spot_all_tok0(stim_k);
      cyc(1'b0, 2'b01, '0, '0, '0);
      spot(stim_k, 0, 10'b1101010100, 0);
      spot(stim_k + 1, 0, 10'b0100000000, -8);
      cyc(1'b0, 2'b01, '0, '0, '0);
      spot(stim_k + 1, 0, 10'b1111111111, 2);
      cyc(1'b0, 2'b00, '0, '0, '0);

      // 0xFF on ch0, 0x00 on ch1, independent counters
      cyc(1'b1, 2'b00, '0, '0, '0);
      cyc(1'b0, 2'b01, 24'h0000FF, '0, '0);
      spot(stim_k + 1, 0, 10'b1000000000, -8);
      spot(stim_k + 1, 1, 10'b0100000000, -8);
      cyc(1'b0, 2'b00, '0, '0, '0);

      // one-cycle control gap clears disparity
      cyc(1'b1, 2'b00, '0, '0, '0);
      cyc(1'b0, 2'b01, '0, '0, '0);
      cyc(1'b0, 2'b01, '0, '0, '0);
      cyc(1'b0, 2'b00, '0, '0, '0);
      spot(stim_k + 1, 0, 10'b1101010100, 0);
      cyc(1'b0, 2'b01, '0, '0, '0);
      spot(stim_k + 1, 0, 10'b0100000000, -8);

      // reset in the middle of a video burst
      repeat (3) cyc(1'b0, 2'b01, {rnd_byte(), rnd_byte(), rnd_byte()}, '0, '0);
      cyc(1'b1, 2'b01, 24'h123456, '0, '0);
      spot_all_tok0(stim_k);
      cyc(1'b0, 2'b01, '0, '0, '0);
      spot(stim_k, 0, 10'b1101010100, 0);
      spot(stim_k + 1, 0, 10'b0100000000, -8);
      cyc(1'b0, 2'b00, '0, '0, '0);

`ifdef HDMI_ISLAND_EN
      // TERC4 island and guard band after a video pixel
      cyc(1'b0, 2'b01, '0, '0, '0);
      cyc(1'b0, 2'b10, '0, '0, 12'h5F0);
      spot(stim_k + 1, 0, 10'b1010011100, 0);
      spot(stim_k + 1, 1, 10'b1011000011, 0);
      spot(stim_k + 1, 2, 10'b0100011110, 0);
      cyc(1'b0, 2'b11, '0, '0, '0);
      spot(stim_k + 1, 0, 10'b1011001100, 0);
      spot(stim_k + 1, 1, 10'b0100110011, 0);
      spot(stim_k + 1, 2, 10'b1011001100, 0);
      cyc(1'b0, 2'b00, '0, '0, '0);
`endif

      // randomized traffic, mostly long video runs
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < NUM_CH; c++) rd[8*c +: 8] = rnd_byte();
         rc = (2*NUM_CH)'($urandom);
         ra = (4*NUM_CH)'($urandom);
         rr = ($urandom_range(0, 49) == 0);
`ifdef HDMI_ISLAND_EN
         rm = ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom_range(0, 3));
`else
         rm = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'b00;
`endif
         cyc(rr, rm, rd, rc, ra);
      end
      repeat (3) cyc(1'b0, 2'b00, '0, '0, '0);

      for (int i = 0; i < 20 && mon_k < stim_k; i++) @(posedge i_clk);
      #2;
      chk("monitor_reached_last_edge", 64'(mon_k >= stim_k), 64'(1));
      chk("sb_drained", 64'(sb.size()), 64'(0));
      chk("spots_drained", 64'(spots.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
